// File: rtl/wb_reg_file_pkg.sv
// wb_reg_file_pkg: shared CPU constants for the write-back stage.
//   CPU_DATA_W : register/data width
//   CPU_ADDR_W : register address width
//   NUM_REGS   : number of general-purpose registers
//   REG_ZERO   : index of the hardwired-zero register
package wb_reg_file_pkg;
   localparam int CPU_DATA_W = 32;
   localparam int CPU_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** CPU_ADDR_W;
   localparam int REG_ZERO   = 0;
endpackage

// File: rtl/wb_read_port.sv
// wb_read_port: one ID-stage register read port with write-through bypass.
//   i_rst_n : active-low reset, forces the port to 0 while held
//   i_addr  : register being read
//   i_we    : effective write enable from write-back
//   i_waddr : register being written this cycle
//   i_wdata : value being written this cycle
//   i_rdata : current stored value of register i_addr
//   o_data  : value seen by ID
module wb_read_port
   import wb_reg_file_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W
) (
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_data
);
   always_comb
      o_data = (!i_rst_n || i_addr == ADDR_W'(REG_ZERO)) ? '0 :
               (i_we && i_addr == i_waddr)                ? i_wdata : i_rdata;
endmodule

// File: rtl/wb_reg_file.sv
// wb_reg_file: write-back stage committing MEM/WB results into the 32-entry GPR file.
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   MemtoReg_i            : select Mem_data_i (1) or ALU_result_i (0)
//   Regwrite_i            : write enable
//   ALU_result_i          : ALU result
//   Mem_data_i            : load data
//   Reg_addr_i            : destination register
//   RSaddr_i / RTaddr_i   : ID read addresses
//   RSdata_o / RTdata_o   : ID read data (combinational, bypassed)
//   wb_data_o             : selected write-back data for EX forwarding
//   wb_count_o            : count of committed register writes
module wb_reg_file
   import wb_reg_file_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemtoReg_i,
   input  logic              Regwrite_i,
   input  logic [DATA_W-1:0] ALU_result_i,
   input  logic [DATA_W-1:0] Mem_data_i,
   input  logic [ADDR_W-1:0] Reg_addr_i,
   input  logic [ADDR_W-1:0] RSaddr_i,
   input  logic [ADDR_W-1:0] RTaddr_i,
   output logic [DATA_W-1:0] RSdata_o,
   output logic [DATA_W-1:0] RTdata_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic [CNT_W-1:0]  wb_count_o
);
   localparam int N_REGS = 2 ** ADDR_W;
   logic [DATA_W-1:0] r_regs [N_REGS];
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] w_wdata;
   logic              w_we;
   always_comb begin
      w_wdata = MemtoReg_i ? Mem_data_i : ALU_result_i;
      w_we    = Regwrite_i && (Reg_addr_i != ADDR_W'(REG_ZERO));
   end
   assign wb_data_o  = w_wdata;
   assign wb_count_o = r_count;
   // Entry 0 is cleared by reset and never written, so it stays 0.
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
         r_count <= '0;
      end else if (w_we) begin
         r_regs[Reg_addr_i] <= w_wdata;
         r_count <= r_count + CNT_W'(1);
      end
   wb_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
      .i_rst_n (rst_i),
      .i_addr  (RSaddr_i),
      .i_we    (w_we),
      .i_waddr (Reg_addr_i),
      .i_wdata (w_wdata),
      .i_rdata (r_regs[RSaddr_i]),
      .o_data  (RSdata_o)
   );
   wb_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
      .i_rst_n (rst_i),
      .i_addr  (RTaddr_i),
      .i_we    (w_we),
      .i_waddr (Reg_addr_i),
      .i_wdata (w_wdata),
      .i_rdata (r_regs[RTaddr_i]),
      .o_data  (RTdata_o)
   );
endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: randomized bench for wb_reg_file against an array-based reference model.
module tb_wb_reg_file;
   logic        clk = 0;
   logic        rst_i = 0;
   logic        MemtoReg_i = 0, Regwrite_i = 0;
   logic [31:0] ALU_result_i = 0, Mem_data_i = 0;
   logic [4:0]  Reg_addr_i = 0, RSaddr_i = 0, RTaddr_i = 0;
   logic [31:0] RSdata_o, RTdata_o, wb_data_o;
   logic [3:0]  wb_count_o;
   int n_checks = 0, n_fail = 0;

   wb_reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .MemtoReg_i(MemtoReg_i), .Regwrite_i(Regwrite_i),
      .ALU_result_i(ALU_result_i), .Mem_data_i(Mem_data_i), .Reg_addr_i(Reg_addr_i),
      .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(RSdata_o), .RTdata_o(RTdata_o),
      .wb_data_o(wb_data_o), .wb_count_o(wb_count_o)
   );

   always #5 clk = ~clk;

   logic [31:0] m_regs [32];
   int unsigned m_cnt;

   function automatic logic [31:0] m_wdata();
      return MemtoReg_i ? Mem_data_i : ALU_result_i;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (!rst_i || a == 0) return 0;
      if (Regwrite_i && Reg_addr_i != 0 && Reg_addr_i == a) return m_wdata();
      return m_regs[a];
   endfunction

   always @(posedge clk or negedge rst_i)
      if (!rst_i) begin
         foreach (m_regs[i]) m_regs[i] = 0;
         m_cnt = 0;
      end else if (Regwrite_i && Reg_addr_i != 0) begin
         m_regs[Reg_addr_i] = m_wdata();
         m_cnt = (m_cnt + 1) % 16;
      end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_rs", RSdata_o, m_read(RSaddr_i));
      check("model_rt", RTdata_o, m_read(RTaddr_i));
      check("model_wb", wb_data_o, m_wdata());
      check("model_cnt", {28'd0, wb_count_o}, m_cnt);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      Regwrite_i = 1; Reg_addr_i = 5; ALU_result_i = 32'h1234; RSaddr_i = 5; RTaddr_i = 5;
      #2;
      check("rst_rs", RSdata_o, 0);
      check("rst_rt", RTdata_o, 0);
      check("rst_cnt", {28'd0, wb_count_o}, 0);
      check("rst_wb", wb_data_o, 32'h1234);
      step(); step();
      rst_i = 1;
      step();
      Regwrite_i = 0;
      #2;
      check("rel_r5", RSdata_o, 32'h1234);
      check("rel_cnt", {28'd0, wb_count_o}, 1);

      MemtoReg_i = 1; Mem_data_i = 32'hDEADBEEF; ALU_result_i = 32'h11;
      Reg_addr_i = 9; Regwrite_i = 1; RSaddr_i = 9; RTaddr_i = 9;
      #2;
      check("byp_rs", RSdata_o, 32'hDEADBEEF);
      check("byp_rt", RTdata_o, 32'hDEADBEEF);
      check("byp_wb", wb_data_o, 32'hDEADBEEF);
      step();
      Regwrite_i = 0;
      #2;
      check("com_rs", RSdata_o, 32'hDEADBEEF);
      check("com_rt", RTdata_o, 32'hDEADBEEF);
      check("com_cnt", {28'd0, wb_count_o}, 2);

      MemtoReg_i = 0; ALU_result_i = 32'hFFFFFFFF; Reg_addr_i = 0; Regwrite_i = 1; RSaddr_i = 0;
      #2;
      check("z_rs_pre", RSdata_o, 0);
      check("z_wb", wb_data_o, 32'hFFFFFFFF);
      step();
      Regwrite_i = 0;
      #2;
      check("z_rs_post", RSdata_o, 0);
      check("z_cnt", {28'd0, wb_count_o}, 2);

      Regwrite_i = 1; Reg_addr_i = 7; ALU_result_i = 32'hAA;
      step();
      Regwrite_i = 0; ALU_result_i = 32'h55; RSaddr_i = 7;
      #2;
      check("wd_pre", RSdata_o, 32'hAA);
      step();
      check("wd_post", RSdata_o, 32'hAA);
      check("wd_cnt", {28'd0, wb_count_o}, 3);

      rst_i = 0; #2; rst_i = 1;
      for (int i = 0; i < 16; i++) begin
         Regwrite_i = 1; Reg_addr_i = 5'(i % 15 + 1); ALU_result_i = $urandom;
         step();
         check("wrap_cnt", {28'd0, wb_count_o}, (i + 1) % 16);
      end

      Reg_addr_i = 2; ALU_result_i = 2; step();
      Reg_addr_i = 3; ALU_result_i = 3; step();
      Reg_addr_i = 4; ALU_result_i = 4; step();
      Regwrite_i = 0; RSaddr_i = 2; RTaddr_i = 4;
      #1;
      check("mid_rs", RSdata_o, 2);
      check("mid_rt", RTdata_o, 4);
      check("mid_cnt", {28'd0, wb_count_o}, 3);
      rst_i = 0;
      #1;
      check("mid_rst_rs", RSdata_o, 0);
      check("mid_rst_rt", RTdata_o, 0);
      check("mid_rst_cnt", {28'd0, wb_count_o}, 0);
      step();
      rst_i = 1;

      for (int i = 0; i < 3000; i++) begin
         step();
         MemtoReg_i   = 1'($urandom);
         Regwrite_i   = ($urandom_range(3) != 0);
         ALU_result_i = $urandom;
         Mem_data_i   = $urandom;
         Reg_addr_i   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
         RSaddr_i     = ($urandom_range(3) == 0) ? Reg_addr_i : 5'($urandom);
         RTaddr_i     = ($urandom_range(3) == 0) ? Reg_addr_i : 5'($urandom);
         if (!rst_i) rst_i = 1;
         else if ($urandom_range(99) == 0) begin
            #1;
            rst_i = 0;
         end
      end
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Write-back consumer of the MEM/WB pipeline register outputs.
- Selects the write-back data (memory data or ALU result) and commits it to a 32-entry general-purpose register file.
- Serves the ID stage through two read ports with same-cycle write-through bypass, so ID never reads a stale value for a register WB is writing.
- Exports the selected write-back value for EX forwarding and a retired-write counter for performance debug.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width (2^ADDR_W registers).
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- MemtoReg_i  in  1  1 = write back Mem_data_i, 0 = write back ALU_result_i.
- Regwrite_i  in  1  write enable from the MEM/WB register.
- ALU_result_i  in  DATA_W  ALU result from the MEM/WB register.
- Mem_data_i  in  DATA_W  load data from the MEM/WB register.
- Reg_addr_i  in  ADDR_W  destination register.
- RSaddr_i  in  ADDR_W  ID read port A address.
- RTaddr_i  in  ADDR_W  ID read port B address.
- RSdata_o  out  DATA_W  read port A data (combinational).
- RTdata_o  out  DATA_W  read port B data (combinational).
- wb_data_o  out  DATA_W  selected write-back data, for forwarding to EX (combinational).
- wb_count_o  out  CNT_W  count of committed register writes (registered).

Behaviour:
- Write-back data: wdata = MemtoReg_i ? Mem_data_i : ALU_result_i.
  - wb_data_o = wdata at all times, independent of Regwrite_i and of reset.
- Effective write: we = Regwrite_i && (Reg_addr_i != 0).
- Commit: on posedge clk_i with rst_i high and we true, regs[Reg_addr_i] <= wdata. Write latency is 1 edge.
- Register 0: hardwired to 0 and never written. Reads of address 0 always return 0, even if Regwrite_i targets address 0.
- Read ports are combinational, evaluated independently for A and B:
  - rst_i low -> 0.
  - Address == 0 -> 0.
  - we && address == Reg_addr_i -> wdata (bypass).
  - Otherwise -> regs[address].
- Both ports may read the same address, including the address being written. Both then return identical data.
- Counter: wb_count_o increments by 1 on each posedge with rst_i high and we true.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Writes to address 0 are not counted.
- Reset (rst_i low, asynchronous, any time including mid-write):
  - All regs and wb_count_o clear to 0 immediately, without a clock edge.
  - Read ports output 0 and bypass is disabled while reset is held.
  - An edge coinciding with active reset commits nothing.
- Reset release: the first rising edge with rst_i high is a normal commit edge.
- No internal pipelining or stall: every MEM/WB beat is consumed in the cycle it is presented.

Decomposition:
- Shared CPU package holds:
  - DATA_W and ADDR_W constants.
  - REG_ZERO = 0.
  - NUM_REGS = 2^ADDR_W.
- One natural sub-module, wb_read_port, instantiated twice (A and B). It contains:
  - The zero-register check.
  - The reset gating.
  - The bypass compare and mux against (we, Reg_addr_i, wdata).
- Storage, write-data mux and counter stay in wb_reg_file.

Test Plan:
- Reset with all inputs active: rst_i=0 while Regwrite_i=1, Reg_addr_i=5, ALU_result_i=0x1234 -> RSdata_o=RTdata_o=0, wb_count_o=0. After release plus 1 edge, reading r5 returns 0x1234 and wb_count_o=1.
- Mux plus commit plus bypass: MemtoReg_i=1, Mem_data_i=0xDEADBEEF, ALU_result_i=0x11, Reg_addr_i=9, Regwrite_i=1, RSaddr_i=RTaddr_i=9 -> both ports read 0xDEADBEEF in the same cycle (before the edge) and after it. wb_data_o=0xDEADBEEF.
- Zero register: Regwrite_i=1, Reg_addr_i=0, ALU_result_i=0xFFFFFFFF, RSaddr_i=0 -> RSdata_o=0 before and after the edge, wb_count_o unchanged, wb_data_o=0xFFFFFFFF.
- Write disabled: Regwrite_i=0, Reg_addr_i=7, data 0x55, r7 previously 0xAA -> RSaddr_i=7 reads 0xAA before and after the edge (no bypass), count unchanged.
- Counter wrap with CNT_W=4: 16 consecutive writes to r1..r15 (cycling) -> wb_count_o counts 1..15 then 0.
- Reset mid-sequence: after 3 writes (r2=0x2, r3=0x3, r4=0x4), assert rst_i between edges -> all reads and wb_count_o drop to 0 immediately, with no clock edge required.
